// File: rtl/lynx_mem_pkg.sv
// lynx_mem_pkg: shared types and defaults for the SDRAM port arbiter.
//   arb_state_t   : arbiter FSM states (IDLE, ACCESS, DONE)
//   arb_src_t     : requester index, also the registered grant encoding
//   *_DEF         : default address/data widths and access window length
//   REQ_*         : bit positions of each requester in the request vector
package lynx_mem_pkg;

  localparam int ADDR_W_DEF        = 24;
  localparam int DATA_W_DEF        = 8;
  localparam int ACCESS_CYCLES_DEF = 6;

  localparam int REQ_VID = 0;
  localparam int REQ_LDR = 1;
  localparam int REQ_CPU = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } arb_state_t;

  typedef enum logic [1:0] {
    SRC_VID = 2'd0,
    SRC_LDR = 2'd1,
    SRC_CPU = 2'd2
  } arb_src_t;

endpackage

// File: rtl/sdram_arb_prio.sv
// sdram_arb_prio: combinational fixed-priority encoder.
//   req   in  [2:0] : request vector, bit order {cpu, ldr, vid}
//   grant out [2:0] : one-hot grant, same bit order; all zero when no request
//   src   out       : index of the granted requester (SRC_VID when none)
// Macro SDRAM_ARB_LOADER_EN: when defined, priority is video > loader > CPU;
// when undefined the loader request is ignored and priority is video > CPU.
module sdram_arb_prio
  import lynx_mem_pkg::*;
(
  input  logic [2:0] req,
  output logic [2:0] grant,
  output arb_src_t   src
);

  // NOTE: every output gets a default before the priority chain so no path
  // through the block leaves a value unassigned, which would infer a latch.
  always_comb begin
    grant = '0;
    src   = SRC_VID;
    if (req[REQ_VID]) begin
      grant[REQ_VID] = 1'b1;
      src            = SRC_VID;
`ifdef SDRAM_ARB_LOADER_EN
    end else if (req[REQ_LDR]) begin
      grant[REQ_LDR] = 1'b1;
      src            = SRC_LDR;
`endif
    end else if (req[REQ_CPU]) begin
      grant[REQ_CPU] = 1'b1;
      src            = SRC_CPU;
    end
  end

`ifndef SDRAM_ARB_LOADER_EN
  logic unused_ldr_req;
  assign unused_ldr_req = req[REQ_LDR];
`endif

endmodule

// File: rtl/sdram_port_arbiter.sv
// sdram_port_arbiter: shares one ssdram controller port among the video
// fetch, the Z80 CPU bus and the ROM/tape loader (clk_sdram domain).
//   clock_i, reset_i          : SDRAM clock, synchronous active-high reset
//   {vid,cpu,ldr}_req_i/addr_i : requests (held until ack) and addresses
//   {cpu,ldr}_we_i/wdata_i     : write strobe / data (video is read-only)
//   {vid,cpu,ldr}_ack_o        : one-cycle completion pulse
//   rdata_o                    : registered read data, valid with any ack
//   mem_addr_o, mem_data_o     : to ssdram addr_i / data_i
//   mem_cs_o/oe_o/we_o         : to ssdram cs_i / oe_i / we_i
//   mem_data_i                 : from ssdram data_o
//   busy_o                     : FSM not in IDLE
// Each access: IDLE (arbitrate, register winner) -> ACCESS for ACCESS_CYCLES
// cycles with cs held -> DONE dead cycle. ACCESS_CYCLES must be >= 2.
// Macro SDRAM_ARB_LOADER_EN: when undefined, ldr_* inputs are ignored and
// ldr_ack_o is tied low.
module sdram_port_arbiter
  import lynx_mem_pkg::*;
#(
  parameter int ADDR_W        = ADDR_W_DEF,
  parameter int DATA_W        = DATA_W_DEF,
  parameter int ACCESS_CYCLES = ACCESS_CYCLES_DEF
) (
  input  logic              clock_i,
  input  logic              reset_i,
  input  logic              vid_req_i,
  input  logic              cpu_req_i,
  input  logic              ldr_req_i,
  input  logic [ADDR_W-1:0] vid_addr_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  input  logic [ADDR_W-1:0] ldr_addr_i,
  input  logic              cpu_we_i,
  input  logic              ldr_we_i,
  input  logic [DATA_W-1:0] cpu_wdata_i,
  input  logic [DATA_W-1:0] ldr_wdata_i,
  output logic              vid_ack_o,
  output logic              cpu_ack_o,
  output logic              ldr_ack_o,
  output logic [DATA_W-1:0] rdata_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_data_o,
  output logic              mem_cs_o,
  output logic              mem_oe_o,
  output logic              mem_we_o,
  input  logic [DATA_W-1:0] mem_data_i,
  output logic              busy_o
);

  localparam int CNT_W = $clog2(ACCESS_CYCLES);

  arb_state_t        state_q, state_d;
  arb_src_t          grant_src, src_q;
  logic [2:0]        grant_oh;
  logic [2:0]        ack_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              start, finish;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              sel_we;

  sdram_arb_prio u_prio (
    .req   ({cpu_req_i, ldr_req_i, vid_req_i}),
    .grant (grant_oh),
    .src   (grant_src)
  );

  // Winner's command fields, selected by the combinational grant in IDLE.
  always_comb begin
    sel_addr  = cpu_addr_i;
    sel_wdata = cpu_wdata_i;
    sel_we    = cpu_we_i;
    case (grant_src)
      SRC_VID: begin
        sel_addr  = vid_addr_i;
        sel_wdata = '0;
        sel_we    = 1'b0;
      end
      SRC_LDR: begin
        sel_addr  = ldr_addr_i;
        sel_wdata = ldr_wdata_i;
        sel_we    = ldr_we_i;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    finish  = 1'b0;
    case (state_q)
      IDLE: begin
        if (|grant_oh) begin
          start   = 1'b1;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (cnt_q == '0) begin
          finish  = 1'b1;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state and outputs are registered with non-blocking assignments so
  // every flop samples the pre-edge values regardless of statement order.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q    <= IDLE;
      src_q      <= SRC_VID;
      ack_q      <= '0;
      cnt_q      <= '0;
      rdata_o    <= '0;
      mem_addr_o <= '0;
      mem_data_o <= '0;
      mem_cs_o   <= 1'b0;
      mem_oe_o   <= 1'b0;
      mem_we_o   <= 1'b0;
    end else begin
      state_q <= state_d;
      ack_q   <= '0;
      if (start) begin
        // Grant and command are frozen here for the whole ACCESS window.
        src_q      <= grant_src;
        mem_addr_o <= sel_addr;
        mem_data_o <= sel_wdata;
        mem_cs_o   <= 1'b1;
        mem_oe_o   <= ~sel_we;
        mem_we_o   <= sel_we;
        cnt_q      <= CNT_W'(ACCESS_CYCLES - 1);
      end else if (state_q == ACCESS && !finish) begin
        cnt_q <= cnt_q - 1'b1;
      end
      if (finish) begin
        mem_cs_o <= 1'b0;
        mem_oe_o <= 1'b0;
        mem_we_o <= 1'b0;
        if (mem_oe_o) begin
          rdata_o <= mem_data_i;
        end
        case (src_q)
          SRC_VID: ack_q[REQ_VID] <= 1'b1;
          SRC_LDR: ack_q[REQ_LDR] <= 1'b1;
          default: ack_q[REQ_CPU] <= 1'b1;
        endcase
      end
    end
  end

  assign busy_o    = (state_q != IDLE);
  assign vid_ack_o = ack_q[REQ_VID];
  assign cpu_ack_o = ack_q[REQ_CPU];
`ifdef SDRAM_ARB_LOADER_EN
  assign ldr_ack_o = ack_q[REQ_LDR];
`else
  assign ldr_ack_o = 1'b0;
  logic unused_ldr_ack;
  assign unused_ldr_ack = ack_q[REQ_LDR];
`endif

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// tb_sdram_port_arbiter: directed self-checking bench for sdram_port_arbiter.
// Expected accesses are queued in service order when requests are driven and
// popped when an ack appears. A small memory model drives mem_data_i.
// Honours SDRAM_ARB_LOADER_EN the same way the design does.
module tb_sdram_port_arbiter;

  localparam int ADDR_W = 24;
  localparam int DATA_W = 8;
  localparam int ACC    = 6;

  typedef struct {
    logic [2:0]        ack;    // {cpu, ldr, vid}
    logic [ADDR_W-1:0] addr;
    logic              we;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
  } exp_t;

  logic              clock_i = 1'b0;
  logic              reset_i;
  logic              vid_req_i, cpu_req_i, ldr_req_i;
  logic [ADDR_W-1:0] vid_addr_i, cpu_addr_i, ldr_addr_i;
  logic              cpu_we_i, ldr_we_i;
  logic [DATA_W-1:0] cpu_wdata_i, ldr_wdata_i;
  logic              vid_ack_o, cpu_ack_o, ldr_ack_o;
  logic [DATA_W-1:0] rdata_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [DATA_W-1:0] mem_data_o;
  logic              mem_cs_o, mem_oe_o, mem_we_o;
  logic [DATA_W-1:0] mem_data_i;
  logic              busy_o;

  int                n_checks = 0;
  int                n_fail   = 0;
  int                cyc      = 0;
  exp_t              sb[$];
  logic [DATA_W-1:0] model_rdata;

  always #5 clock_i = ~clock_i;
  always @(posedge clock_i) cyc <= cyc + 1;

  function automatic logic [DATA_W-1:0] model_rd(input logic [ADDR_W-1:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h83;
  endfunction

  assign mem_data_i = model_rd(mem_addr_o);

  sdram_port_arbiter dut (
    .clock_i     (clock_i),
    .reset_i     (reset_i),
    .vid_req_i   (vid_req_i),
    .cpu_req_i   (cpu_req_i),
    .ldr_req_i   (ldr_req_i),
    .vid_addr_i  (vid_addr_i),
    .cpu_addr_i  (cpu_addr_i),
    .ldr_addr_i  (ldr_addr_i),
    .cpu_we_i    (cpu_we_i),
    .ldr_we_i    (ldr_we_i),
    .cpu_wdata_i (cpu_wdata_i),
    .ldr_wdata_i (ldr_wdata_i),
    .vid_ack_o   (vid_ack_o),
    .cpu_ack_o   (cpu_ack_o),
    .ldr_ack_o   (ldr_ack_o),
    .rdata_o     (rdata_o),
    .mem_addr_o  (mem_addr_o),
    .mem_data_o  (mem_data_o),
    .mem_cs_o    (mem_cs_o),
    .mem_oe_o    (mem_oe_o),
    .mem_we_o    (mem_we_o),
    .mem_data_i  (mem_data_i),
    .busy_o      (busy_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clock_i);
  endtask

  task automatic push(input logic [2:0] ack, input logic [ADDR_W-1:0] addr,
                      input logic we, input logic [DATA_W-1:0] wdata);
    exp_t e;
    if (!we) model_rdata = model_rd(addr);
    e.ack   = ack;
    e.addr  = addr;
    e.we    = we;
    e.wdata = wdata;
    e.rdata = model_rdata;
    sb.push_back(e);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_acks"}, {29'd0, cpu_ack_o, ldr_ack_o, vid_ack_o}, 32'd0);
    check({tag, "_ctl"},  {29'd0, mem_cs_o, mem_oe_o, mem_we_o}, 32'd0);
    check({tag, "_addr"}, 32'(mem_addr_o), 32'd0);
    check({tag, "_data"}, 32'(mem_data_o), 32'd0);
    check({tag, "_rdata"}, 32'(rdata_o), 32'd0);
    check({tag, "_busy"}, 32'(busy_o), 32'd0);
  endtask

  // Called on the negedge before the arbitrating posedge. Waits for an ack,
  // compares it with the scoreboard head, drops that request unless hold is
  // set, and checks the ack is a single-cycle pulse.
  task automatic expect_ack(input string tag, input bit hold, output int ack_cyc);
    exp_t       e;
    logic [2:0] acks;
    int         n, cs_cnt, oe_cnt, we_cnt;
    n = 0; cs_cnt = 0; oe_cnt = 0; we_cnt = 0; ack_cyc = 0;
    acks = '0;
    while (n < 40) begin
      acks = {cpu_ack_o, ldr_ack_o, vid_ack_o};
      if (acks != 3'b000) break;
      cs_cnt += int'(mem_cs_o);
      oe_cnt += int'(mem_oe_o);
      we_cnt += int'(mem_we_o);
      tick(1);
      n++;
    end
    check({tag, "_ack_seen"}, 32'(acks != 3'b000), 32'd1);
    if (acks != 3'b000 && sb.size() > 0) begin
      e = sb.pop_front();
      ack_cyc = cyc;
      check({tag, "_ack_src"}, 32'(acks), 32'(e.ack));
      check({tag, "_latency"}, 32'(n - 1), 32'(ACC));
      check({tag, "_cs_cycles"}, 32'(cs_cnt), 32'(ACC));
      check({tag, "_oe_cycles"}, 32'(oe_cnt), e.we ? 32'd0 : 32'(ACC));
      check({tag, "_we_cycles"}, 32'(we_cnt), e.we ? 32'(ACC) : 32'd0);
      check({tag, "_cs_drop"}, 32'(mem_cs_o), 32'd0);
      check({tag, "_addr"}, 32'(mem_addr_o), 32'(e.addr));
      if (e.we) check({tag, "_wdata"}, 32'(mem_data_o), 32'(e.wdata));
      check({tag, "_rdata"}, 32'(rdata_o), 32'(e.rdata));
      if (!hold) begin
        if (e.ack[0]) vid_req_i = 1'b0;
        if (e.ack[1]) ldr_req_i = 1'b0;
        if (e.ack[2]) cpu_req_i = 1'b0;
      end
      tick(1);
      check({tag, "_ack_pulse"}, {29'd0, cpu_ack_o, ldr_ack_o, vid_ack_o}, 32'd0);
    end
  endtask

  initial begin
    int t0, t1, t2, cs_cnt, ldr_acks;
    reset_i = 1'b1;
    vid_req_i = 1'b0; cpu_req_i = 1'b0; ldr_req_i = 1'b0;
    vid_addr_i = '0; cpu_addr_i = '0; ldr_addr_i = '0;
    cpu_we_i = 1'b0; ldr_we_i = 1'b0;
    cpu_wdata_i = '0; ldr_wdata_i = '0;
    model_rdata = '0;

    // Reset state.
    tick(3);
    check_zero("reset");
    reset_i = 1'b0;
    tick(2);

    // CPU read of 0x001234 returns 0xA5.
    cpu_addr_i = 24'h001234; cpu_we_i = 1'b0; cpu_req_i = 1'b1;
    push(3'b100, 24'h001234, 1'b0, '0);
    check("model_a5", 32'(model_rd(cpu_addr_i)), 32'h0000_00a5);
    expect_ack("cpu_rd", 1'b0, t0);
    check("idle_after_done", 32'(busy_o), 32'd0);

    // All requesters rise together.
    vid_addr_i = 24'h00abcd; ldr_addr_i = 24'h000200; cpu_addr_i = 24'h004321;
    vid_req_i = 1'b1; ldr_req_i = 1'b1; cpu_req_i = 1'b1;
    push(3'b001, 24'h00abcd, 1'b0, '0);
`ifdef SDRAM_ARB_LOADER_EN
    push(3'b010, 24'h000200, 1'b0, '0);
    push(3'b100, 24'h004321, 1'b0, '0);
    expect_ack("sim_vid", 1'b0, t0);
    expect_ack("sim_ldr", 1'b0, t1);
    expect_ack("sim_cpu", 1'b0, t2);
    check("sim_gap1", 32'(t1 - t0), 32'(ACC + 2));
    check("sim_gap2", 32'(t2 - t1), 32'(ACC + 2));
`else
    push(3'b100, 24'h004321, 1'b0, '0);
    expect_ack("sim_vid", 1'b0, t0);
    expect_ack("sim_cpu", 1'b0, t1);
    check("sim_gap1", 32'(t1 - t0), 32'(ACC + 2));
    // Loader request still high but compiled out: nothing may start.
    cs_cnt = 0; ldr_acks = 0;
    for (int i = 0; i < 12; i++) begin
      tick(1);
      cs_cnt   += int'(mem_cs_o);
      ldr_acks += int'(ldr_ack_o);
    end
    check("ldr_off_cs", 32'(cs_cnt), 32'd0);
    check("ldr_off_ack", 32'(ldr_acks), 32'd0);
    ldr_req_i = 1'b0;
`endif
    tick(1);

    // Video read at the top of the address space.
    vid_addr_i = 24'hffffff; vid_req_i = 1'b1;
    push(3'b001, 24'hffffff, 1'b0, '0);
    expect_ack("vid_max", 1'b0, t0);

    // CPU write: rdata_o must keep the previous read value.
    cpu_addr_i = 24'h000100; cpu_we_i = 1'b1; cpu_wdata_i = 8'h5e; cpu_req_i = 1'b1;
    push(3'b100, 24'h000100, 1'b1, 8'h5e);
    expect_ack("cpu_wr", 1'b0, t0);
    cpu_we_i = 1'b0;

`ifdef SDRAM_ARB_LOADER_EN
    // Loader write 0x3C to 0x000100.
    ldr_addr_i = 24'h000100; ldr_we_i = 1'b1; ldr_wdata_i = 8'h3c; ldr_req_i = 1'b1;
    push(3'b010, 24'h000100, 1'b1, 8'h3c);
    expect_ack("ldr_wr", 1'b0, t0);
    ldr_we_i = 1'b0;
`endif

    // Reset pulsed on cycle 3 of a CPU read; request held through reset.
    cpu_addr_i = 24'h000555; cpu_req_i = 1'b1;
    tick(3);
    check("mid_cs_before_reset", 32'(mem_cs_o), 32'd1);
    reset_i = 1'b1;
    tick(1);
    check_zero("mid_reset");
    reset_i = 1'b0;
    model_rdata = '0;
    push(3'b100, 24'h000555, 1'b0, '0);
    expect_ack("after_reset", 1'b0, t0);

    // Held CPU request gives two accesses back to back.
    cpu_addr_i = 24'h00beef; cpu_req_i = 1'b1;
    push(3'b100, 24'h00beef, 1'b0, '0);
    push(3'b100, 24'h00beef, 1'b0, '0);
    expect_ack("held_1", 1'b1, t0);
    expect_ack("held_2", 1'b0, t1);
    check("held_gap", 32'(t1 - t0), 32'(ACC + 2));
    check("sb_drained", 32'(sb.size()), 32'd0);

    tick(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/sdram_port_arbiter.md
# sdram_port_arbiter

Shares the single `ssdram` controller port among three requesters: the video fetch, the Z80 CPU bus and the ROM/tape image loader. Runs in the SDRAM clock domain, ahead of `ssdram` in the top level. Each access follows a fixed-priority grant and a fixed-length command window. Completion is reported to the winning requester with a one-cycle acknowledge and registered read data.

## Interface
Parameters:
- `ADDR_W`, 24: SDRAM byte address width.
- `DATA_W`, 8: data width.
- `ACCESS_CYCLES`, 6: cycles `cs_o` is held per access; must be ≥ 2 and no less than `ssdram` read latency at 96 MHz.

Ports:
- `clock_i` in 1: SDRAM clock (`clk_sdram`).
- `reset_i` in 1: synchronous, active-high reset.
- `vid_req_i`, `cpu_req_i`, `ldr_req_i` in 1 each: request, held until ack.
- `vid_addr_i`, `cpu_addr_i`, `ldr_addr_i` in `ADDR_W`: address.
- `cpu_we_i`, `ldr_we_i` in 1: write strobe. Video is read-only.
- `cpu_wdata_i`, `ldr_wdata_i` in `DATA_W`: write data.
- `vid_ack_o`, `cpu_ack_o`, `ldr_ack_o` out 1: one-cycle completion pulse.
- `rdata_o` out `DATA_W`: read data, shared by all requesters and valid with any ack.
- `mem_addr_o` out `ADDR_W`, `mem_data_o` out `DATA_W`: to `ssdram` `addr_i` / `data_i`.
- `mem_cs_o`, `mem_oe_o`, `mem_we_o` out 1: to `ssdram` `cs_i`, `oe_i`, `we_i`.
- `mem_data_i` in `DATA_W`: from `ssdram` `data_o`.
- `busy_o` out 1: high whenever the FSM is not in IDLE.

## Operation
- FSM states are IDLE, ACCESS, DONE.
- **IDLE:** samples the requests. Priority is video > loader > CPU.
    - The winner's address, write data and write strobe are registered into `mem_*`.
    - `mem_cs_o` is raised, together with `mem_oe_o` (read) or `mem_we_o` (write).
    - The cycle counter is loaded with `ACCESS_CYCLES-1` and the FSM goes to ACCESS.
- **ACCESS:** the counter decrements each cycle. At 0:
    - `mem_data_i` is latched into `rdata_o` on reads only; it is held on writes.
    - `mem_cs_o`, `mem_oe_o` and `mem_we_o` drop.
    - The granted ack pulses.
    - The FSM goes to DONE.
- **DONE:** one dead cycle, then IDLE.
    - The requester must deassert `req` in the cycle it sees ack.
    - `req` still high at the IDLE sample is treated as a new request.
- **Grant stability:** the grant index and `mem_*` registers are frozen through ACCESS. Request changes during ACCESS are ignored.
- **Simultaneous requests:** only the highest-priority requester is served. The others stay pending and are re-arbitrated in the next IDLE.
- **Requests dropped early:** a requester that drops `req` before ack still has its access completed and its ack pulsed.
- **Addresses:** no wrap or alignment checks. The address is passed through unchanged.

## Timing
- Reset values of all outputs are 0: acks, `mem_cs_o`, `mem_oe_o`, `mem_we_o`, `mem_addr_o`, `mem_data_o`, `rdata_o` and `busy_o`. The state is IDLE.
- Reset asserted mid-ACCESS aborts the access on the next edge. No ack is issued and `rdata_o` clears.
- Latency from `req` sampled high in IDLE to ack is `ACCESS_CYCLES` cycles (6 by default).
- Occupancy is `ACCESS_CYCLES+2` cycles per access, including IDLE and DONE.
- Worst case for the CPU with the video requesting back-to-back is unbounded. The video fetch must leave gaps, and this is the video fetch's responsibility.
- `rdata_o` is stable from the ack cycle until the next read completes.

## Configuration
- `SDRAM_ARB_LOADER_EN`: **defined** — the loader port participates as described.
- **Undefined:**
    - `ldr_*` inputs are ignored and `ldr_ack_o` is tied 0.
    - Arbitration is video > CPU only.
    - The grant encoding keeps the same width.

## Structure
- Shared package `lynx_mem_pkg` contains:
    - the state enum `arb_state_t` (IDLE, ACCESS, DONE);
    - the requester index enum `arb_src_t` (SRC_VID, SRC_LDR, SRC_CPU);
    - `ACCESS_CYCLES` default and `ADDR_W` / `DATA_W` defaults.
- One sub-module, `sdram_arb_prio`: a combinational fixed-priority encoder (req vector in, one-hot grant and `arb_src_t` out). It honours `SDRAM_ARB_LOADER_EN`.

## Test plan
- **CPU read:** CPU read of 0x001234 with memory model returning 0xA5 → `mem_oe_o`/`mem_cs_o` high for 6 cycles. `cpu_ack_o` pulses 6 cycles after the request is sampled, with `rdata_o` = 0xA5.
- **Simultaneous:** `vid_req_i`, `ldr_req_i` and `cpu_req_i` all rise in the same cycle → acks arrive in the order video, loader, CPU, spaced 8 cycles apart.
- **Loader write:** loader write 0x3C to 0x000100 → `mem_we_o` high for 6 cycles, `mem_data_o` = 0x3C, `rdata_o` unchanged, `ldr_ack_o` single pulse.
- **Reset mid-access:** `reset_i` pulsed on cycle 3 of a CPU read → all outputs 0 on the next edge, no `cpu_ack_o`. A request held through reset is served normally after release.
- **Held request:** `cpu_req_i` held high after ack → a second access starts at the following IDLE, giving two acks 8 cycles apart.
- **Loader compiled out:** build without `SDRAM_ARB_LOADER_EN` and drive `ldr_req_i` high → no `mem_cs_o` and `ldr_ack_o` = 0. CPU and video accesses are unaffected.
